router_input_port: RTL and testbench
====================================

Name: router_input_port

Overview:
- Per-input ingress stage of the 16x16 router; one instance for each of the 16 serial inputs.
- Deserializes the 4-bit destination address from the serial frame and raises a one-hot request toward the 16 per-output arbiters.
- Buffers payload bits in a bit-wide FIFO while waiting for a grant.
- Once granted, drains payload bits to the crossbar; holds the request until the packet's last bit leaves, so the arbiter's grant stays locked.

Parameters:
- DEPTH, 32, payload FIFO depth in bits (power of 2, >=4).
- PAD_CYCLES, 5, pad cycles between address and payload.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- din  in  1  serial data in.
- frame_n  in  1  active-low frame marker; low from first address bit through last payload bit.
- valid_n  in  1  active-low payload-bit qualifier; ignored during address and pad.
- grant  in  16  grant[k] = this input's grant bit from output k's arbiter.
- request  out  16  one-hot request to output arbiters.
- out_data  out  1  payload bit to crossbar.
- out_valid  out  1  out_data valid.
- out_last  out  1  final payload bit of packet, coincident with out_valid.
- port_busy  out  1  high from first address bit until packet fully drained.
- err  out  1  sticky: protocol error or drop; cleared only by reset.

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE. Applies immediately and asynchronously.
- Reset mid-packet discards the packet and deasserts request at once.
- States:
  - IDLE: frame_n=0 samples din as addr[0] -> ADDR, bit count 1.
  - ADDR: samples addr[1..3] LSB-first on the next 3 cycles. After addr[3] -> PAD. request[addr] is asserted from the next cycle (registered).
  - PAD: stays PAD_CYCLES cycles -> PAYLOAD.
  - PAYLOAD: each cycle with valid_n=0 pushes din. The cycle where frame_n rises (with valid_n=0) pushes the last bit, marks it last (FIFO stores 2 bits/entry: data, last) -> DRAIN.
  - DRAIN: request held until the last bit is popped, then request=0 -> IDLE the following cycle.
- Early frame_n rise in ADDR or PAD: set err, no request, -> IDLE.
- frame_n rise in PAYLOAD with valid_n=1 and no bits pushed: set err, no request, -> IDLE.
- frame_n rise in PAYLOAD with valid_n=1 after bits were pushed: previous pushed bit becomes last.
- Frame start (frame_n=0 with IDLE condition) while port_busy=1 and not IDLE: frame ignored until frame_n=1, err set.
- Pop and forward:
  - pop when (grant & request)!=0 and FIFO non-empty; one bit per cycle.
  - out_data/out_valid/out_last are registered, one cycle after the pop.
  - out_valid=0 whenever not popping.
- Grant is not checked against address; grant bits for other outputs are ignored.
- Grant lost mid-drain: popping stops; bits are retained; resumes on re-grant.
- FIFO full in PAYLOAD on a push: the bit is dropped and err is set.
- If the last bit is dropped, the previous entry is marked last.
- If the FIFO is empty when the drop occurs, the packet aborts: request cleared, -> IDLE.
- Simultaneous push and pop when full: allowed, no drop.
- Pointers are log2(DEPTH)+1 bits; full/empty use MSB compare; pointers wrap modulo 2*DEPTH.
- request is exactly one-hot or zero at all times.
- port_busy = state!=IDLE.

Optional Feature:
- Macro: ROUTER_PKT_COUNT_EN.
- When defined: adds outputs pkt_count (16 bits) and drop_count (16 bits).
  - pkt_count increments on each out_last.
  - drop_count increments on each bit dropped or frame aborted.
  - Both reset to 0 and saturate at 0xFFFF.
- When undefined: ports absent; no counters synthesized.

Test Plan:
- Address 4'b1010 (din 0,1,0,1), 5 pad, 8 payload bits 10110011, grant[10] tied to request[10] -> request=16'h0400 after addr[3].
  - Bits emerge in order with out_last on the 8th.
  - request=0 the cycle after the last pop; pkt_count=1.
- Same packet with grant withheld 20 cycles, then granted -> request=16'h0400 held throughout.
  - No output before grant; all 8 bits delivered after grant; err=0.
- DEPTH=32, 40 payload bits, no grant until frame end -> 8 bits dropped, err=1, drop_count=8.
  - 32 bits delivered, last marked on bit 32.
- frame_n rises after 2 address bits -> request stays 0, err=1, state IDLE; a following valid packet to address 3 gives request=16'h0008.
- grant deasserted for 3 cycles mid-drain -> out_valid=0 those cycles; payload intact and in order.
- reset pulsed during DRAIN -> request, out_valid, port_busy, err = 0 immediately (asynchronous); FIFO empty.

Source files
------------

// File: rtl/router_input_port.sv
// Ingress stage for one serial input of the 16x16 router.
// Deserializes a 4-bit LSB-first destination address, raises a one-hot request
// toward the output arbiters, buffers payload bits in a FIFO and drains them to
// the crossbar once granted. The request stays up until the last bit leaves.
// Optional packet/drop counters are enabled by defining ROUTER_PKT_COUNT_EN.
module router_input_port #(
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned PAD_CYCLES = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        din,
    input  logic        frame_n,
    input  logic        valid_n,
    input  logic [15:0] grant,
    output logic [15:0] request,
    output logic        out_data,
    output logic        out_valid,
    output logic        out_last,
    output logic        port_busy,
    output logic        err
`ifdef ROUTER_PKT_COUNT_EN
    ,
    output logic [15:0] pkt_count,
    output logic [15:0] drop_count
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = (PAD_CYCLES > 1) ? $clog2(PAD_CYCLES) : 1;
    localparam logic [PW-1:0] PadLast = PW'(PAD_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StAddr, StPad, StPayload, StDrain} state_e;

    state_e        state_q, state_d;
    logic [1:0]    bit_cnt_q, bit_cnt_d;
    logic [2:0]    addr_q, addr_d;
    logic [PW-1:0] pad_cnt_q, pad_cnt_d;
    logic          pushed_q, pushed_d;
    logic          skip_q, skip_d;
    logic [15:0]   request_q, request_d;
    logic          err_q, err_d;
    logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic          out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;

    // Each entry holds {data, last}.
    logic [1:0]    mem [DEPTH];

    logic          empty, full, can_push, pop;
    logic [AW:0]   fill;
    logic [AW-1:0] wr_prev;
    logic [1:0]    pop_entry;
    logic          push_req, push, drop, mark_prev, abort, done;

    assign empty     = (wptr_q == rptr_q);
    assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign fill      = wptr_q - rptr_q;
    assign wr_prev   = wptr_q[AW-1:0] - AW'(1);
    assign pop       = (|(grant & request_q)) && !empty;
    assign pop_entry = mem[rptr_q[AW-1:0]];
    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign can_push  = !full || pop;

    assign request   = request_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign port_busy = (state_q != StIdle);
    assign err       = err_q;

    // Packet FSM next-state, FIFO control and forwarding outputs.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        addr_d      = addr_q;
        pad_cnt_d   = pad_cnt_q;
        pushed_d    = pushed_q;
        skip_d      = skip_q;
        request_d   = request_q;
        err_d       = err_q;
        push_req    = 1'b0;
        mark_prev   = 1'b0;
        abort       = 1'b0;
        done        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!frame_n && !skip_q) begin
                    state_d   = StAddr;
                    addr_d    = {2'b00, din};
                    bit_cnt_d = 2'd1;
                    pushed_d  = 1'b0;
                end
            end
            StAddr: begin
                if (frame_n) begin
                    abort = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + 2'd1;
                    case (bit_cnt_q)
                        2'd1: addr_d[1] = din;
                        2'd2: addr_d[2] = din;
                        2'd3: begin
                            request_d = 16'h0001 << {din, addr_q};
                            pad_cnt_d = '0;
                            state_d   = (PAD_CYCLES == 0) ? StPayload : StPad;
                        end
                        default: ;
                    endcase
                end
            end
            StPad: begin
                if (frame_n) begin
                    abort = 1'b1;
                end else if (pad_cnt_q == PadLast) begin
                    state_d = StPayload;
                end else begin
                    pad_cnt_d = pad_cnt_q + PW'(1);
                end
            end
            StPayload: begin
                push_req = !valid_n;
                if (frame_n) begin
                    if (!valid_n && can_push) begin
                        state_d = StDrain;
                    end else if (!valid_n || pushed_q) begin
                        // Final bit dropped or never qualified: retag the previous entry.
                        if (empty) begin
                            abort = 1'b1;
                        end else begin
                            mark_prev = 1'b1;
                            if (pop && fill == (AW+1)'(1)) begin
                                done = 1'b1;
                            end else begin
                                state_d = StDrain;
                            end
                        end
                    end else begin
                        abort = 1'b1;
                    end
                end
            end
            StDrain: begin
                if (!frame_n) begin
                    err_d  = 1'b1;
                    skip_d = 1'b1;
                end
                if (pop && pop_entry[0]) begin
                    done = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        push = push_req && can_push;
        drop = push_req && !can_push;
        if (push) begin
            pushed_d = 1'b1;
        end
        if (drop) begin
            err_d = 1'b1;
        end
        if (abort) begin
            err_d     = 1'b1;
            request_d = '0;
            state_d   = StIdle;
        end
        if (done) begin
            request_d = '0;
            state_d   = StIdle;
        end
        // A frame ignored while busy is skipped until its frame_n rises.
        if (frame_n) begin
            skip_d = 1'b0;
        end

        wptr_d      = wptr_q + (AW+1)'(push);
        rptr_d      = rptr_q + (AW+1)'(pop);
        out_valid_d = pop;
        out_data_d  = pop & pop_entry[1];
        out_last_d  = pop & (pop_entry[0] | (mark_prev && fill == (AW+1)'(1)));
    end

    // Control state, pointers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            addr_q      <= '0;
            pad_cnt_q   <= '0;
            pushed_q    <= 1'b0;
            skip_q      <= 1'b0;
            request_q   <= '0;
            err_q       <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            out_data_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            addr_q      <= addr_d;
            pad_cnt_q   <= pad_cnt_d;
            pushed_q    <= pushed_d;
            skip_q      <= skip_d;
            request_q   <= request_d;
            err_q       <= err_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    // FIFO storage; emptiness is tracked by the pointers so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q[AW-1:0]] <= {din, frame_n};
        end else if (mark_prev) begin
            mem[wr_prev][0] <= 1'b1;
        end
    end

`ifdef ROUTER_PKT_COUNT_EN
    logic [15:0] pkt_count_q, drop_count_q;

    assign pkt_count  = pkt_count_q;
    assign drop_count = drop_count_q;

    // Saturating packet and drop counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            if (out_last_d && pkt_count_q != 16'hFFFF) begin
                pkt_count_q <= pkt_count_q + 16'd1;
            end
            if ((drop || abort) && drop_count_q != 16'hFFFF) begin
                drop_count_q <= drop_count_q + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_router_input_port.sv
// Directed self-checking bench for router_input_port (DEPTH=32, PAD_CYCLES=5).
module tb_router_input_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        din;
    logic        frame_n;
    logic        valid_n;
    logic [15:0] grant;
    logic [15:0] grant_drv;
    logic        tie;
    logic [15:0] request;
    logic        out_data;
    logic        out_valid;
    logic        out_last;
    logic        port_busy;
    logic        err;
`ifdef ROUTER_PKT_COUNT_EN
    logic [15:0] pkt_count;
    logic [15:0] drop_count;
`endif

    int checks = 0;
    int errors = 0;
    int onehot_bad = 0;
    logic rx_data[$];
    logic rx_last[$];

    always #5 clk = ~clk;

    assign grant = grant_drv | (tie ? request : 16'h0000);

    router_input_port #(
        .DEPTH      (32),
        .PAD_CYCLES (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .frame_n    (frame_n),
        .valid_n    (valid_n),
        .grant      (grant),
        .request    (request),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .port_busy  (port_busy),
        .err        (err)
`ifdef ROUTER_PKT_COUNT_EN
        ,
        .pkt_count  (pkt_count),
        .drop_count (drop_count)
`endif
    );

    // Collect forwarded bits and watch the request encoding.
    always @(negedge clk) begin
        if (out_valid) begin
            rx_data.push_back(out_data);
            rx_last.push_back(out_last);
        end
        if ((request & (request - 16'd1)) != 16'h0000) onehot_bad++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        frame_n = 1'b1;
        valid_n = 1'b1;
        din     = 1'b0;
    endtask

    task automatic send_addr(input logic [3:0] addr);
        for (int i = 0; i < 4; i++) begin
            frame_n = 1'b0;
            valid_n = 1'b1;
            din     = addr[i];
            tick();
        end
    endtask

    task automatic send_pad_payload(input int n, input logic [63:0] bits);
        for (int i = 0; i < 5; i++) begin
            din = 1'b0;
            tick();
        end
        for (int i = 0; i < n; i++) begin
            din     = bits[i];
            valid_n = 1'b0;
            frame_n = (i == n - 1);
            tick();
        end
        idle_inputs();
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (port_busy && k < 300) begin
            tick();
            k++;
        end
        check_eq(tag, {63'd0, port_busy}, 64'd0);
        tick();
    endtask

    task automatic check_rx(input string tag, input int n, input logic [63:0] data,
                            input logic [63:0] lastmask);
        logic [63:0] gd;
        logic [63:0] gl;
        gd = '0;
        gl = '0;
        for (int i = 0; i < rx_data.size() && i < 64; i++) begin
            gd[i] = rx_data[i];
            gl[i] = rx_last[i];
        end
        check_eq({tag, " count"}, 64'(rx_data.size()), 64'(n));
        check_eq({tag, " data"}, gd, data);
        check_eq({tag, " last"}, gl, lastmask);
        rx_data.delete();
        rx_last.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        int bad;
        idle_inputs();
        grant_drv = '0;
        tie       = 1'b0;
        do_reset();

        check_eq("reset request", 64'(request), 64'h0);
        check_eq("reset busy", {63'd0, port_busy}, 64'd0);
        check_eq("reset err", {63'd0, err}, 64'd0);
        check_eq("reset out_valid", {63'd0, out_valid}, 64'd0);

        // Basic packet to output 10 with its grant following the request.
        tie = 1'b1;
        send_addr(4'b1010);
        check_eq("t1 request", 64'(request), 64'h0400);
        check_eq("t1 busy", {63'd0, port_busy}, 64'd1);
        send_pad_payload(8, 64'hCD);
        wait_idle("t1 idle");
        check_eq("t1 request off", 64'(request), 64'h0);
        check_rx("t1 rx", 8, 64'hCD, 64'h80);
        check_eq("t1 err", {63'd0, err}, 64'd0);
`ifdef ROUTER_PKT_COUNT_EN
        check_eq("t1 pkt_count", 64'(pkt_count), 64'd1);
`endif
        tie = 1'b0;

        // Grant withheld 20 cycles after the frame ends.
        send_addr(4'b1010);
        send_pad_payload(8, 64'hCD);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (request != 16'h0400) bad++;
            tick();
        end
        check_eq("t2 request held", 64'(bad), 64'd0);
        check_eq("t2 no early output", 64'(rx_data.size()), 64'd0);
        grant_drv = 16'h0401;
        wait_idle("t2 idle");
        grant_drv = '0;
        check_rx("t2 rx", 8, 64'hCD, 64'h80);
        check_eq("t2 err", {63'd0, err}, 64'd0);

        // Overflow: 40 bits into a 32-deep FIFO with no grant.
        do_reset();
        send_addr(4'hF);
        check_eq("t3 request", 64'(request), 64'h8000);
        send_pad_payload(40, 64'h0000_00C7_5A3C_E1F4);
        check_eq("t3 err", {63'd0, err}, 64'd1);
        check_eq("t3 request held", 64'(request), 64'h8000);
`ifdef ROUTER_PKT_COUNT_EN
        check_eq("t3 drop_count", 64'(drop_count), 64'd8);
`endif
        grant_drv = 16'h8000;
        wait_idle("t3 idle");
        grant_drv = '0;
        check_rx("t3 rx", 32, 64'h5A3C_E1F4, 64'h8000_0000);

        // Early frame end after two address bits, then a good packet to output 3.
        do_reset();
        frame_n = 1'b0; din = 1'b1; tick();
        din = 1'b0; tick();
        idle_inputs(); tick();
        check_eq("t4 abort request", 64'(request), 64'h0);
        check_eq("t4 abort err", {63'd0, err}, 64'd1);
        check_eq("t4 abort busy", {63'd0, port_busy}, 64'd0);
        tie = 1'b1;
        send_addr(4'd3);
        check_eq("t4 request", 64'(request), 64'h0008);
        send_pad_payload(4, 64'h9);
        wait_idle("t4 idle");
        check_rx("t4 rx", 4, 64'h9, 64'h8);
        tie = 1'b0;

        // Grant dropped for three cycles mid-drain.
        do_reset();
        send_addr(4'h5);
        send_pad_payload(16, 64'hB26D);
        grant_drv = 16'h0020;
        for (int i = 0; i < 4; i++) tick();
        grant_drv = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t5 paused out_valid", {63'd0, out_valid}, 64'd0);
        end
        grant_drv = 16'h0020;
        wait_idle("t5 idle");
        grant_drv = '0;
        check_rx("t5 rx", 16, 64'hB26D, 64'h8000);

        // Asynchronous reset during drain.
        do_reset();
        frame_n = 1'b0; din = 1'b1; tick();
        idle_inputs(); tick();
        check_eq("t6 pre err", {63'd0, err}, 64'd1);
        send_addr(4'h2);
        send_pad_payload(8, 64'h3C);
        grant_drv = 16'h0004;
        tick();
        tick();
        check_eq("t6 pre out_valid", {63'd0, out_valid}, 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("t6 request", 64'(request), 64'h0);
        check_eq("t6 out_valid", {63'd0, out_valid}, 64'd0);
        check_eq("t6 busy", {63'd0, port_busy}, 64'd0);
        check_eq("t6 err", {63'd0, err}, 64'd0);
        tick();
        reset = 1'b0;
        grant_drv = '0;
        tick();
        rx_data.delete();
        rx_last.delete();
        tie = 1'b1;
        send_addr(4'h2);
        send_pad_payload(4, 64'h6);
        wait_idle("t6 idle");
        check_rx("t6 rx after reset", 4, 64'h6, 64'h8);
        tie = 1'b0;

        check_eq("request one-hot", 64'(onehot_bad), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
